tdm_mux8_rr: RTL
================

// Module: tdm_mux8_rr
// PURPOSE
//  Round-robin time-division multiplexer: merges N_CH valid/ready input channels into one output stream.
//  Each output beat is tagged with its source channel index (out_sel).
//  This is the gathering end of the 1:8 demux fabric: the out_sel/out_data pair drives a demux sel/I directly.
//  Sits between per-channel producers and a single shared downstream consumer.
// PARAMETERS
//  DATA_W  1  width of each channel's data word
//  N_CH    8  number of input channels (power of 2, 2..16)
//  SEL_W   $clog2(N_CH)  localparam, channel index width (3 at default)
// PORTS
//  clk        in   1             rising-edge clock
//  rst        in   1             synchronous, active-high reset
//  in_valid   in   N_CH          per-channel data valid
//  in_data    in   N_CH*DATA_W   channel i occupies bits [i*DATA_W +: DATA_W]
//  in_ready   out  N_CH          per-channel accept; at most one bit high per cycle
//  out_valid  out  1             output beat valid
//  out_data   out  DATA_W        output data
//  out_sel    out  SEL_W         source channel index of out_data
//  out_ready  in   1             downstream accept
// BEHAVIOUR
//  - Reset (clk edge with rst=1): out_valid=0, out_data=0, out_sel=0, ptr=0; in_ready=0 while rst=1.
//  - Output register is 2-state FSM: EMPTY (out_valid=0) / FULL (out_valid=1).
//  - load = !out_valid | out_ready. Grant evaluated only when load=1; otherwise in_ready=0.
//  - Grant: first i with in_valid[i]=1 searching ptr, ptr+1, ... mod N_CH; in_ready[i]=1 combinationally (from in_valid, ptr, out_valid, out_ready).
//  - Transfer on input side when in_valid[i] & in_ready[i]; on output side when out_valid & out_ready.
//  - On input transfer: next cycle out_valid=1, out_data=in_data[i], out_sel=i, ptr=(i+1) mod N_CH.
//  - Latency: 1 cycle from input accept to out_valid. Throughput: 1 beat/cycle with out_ready=1.
//  - EMPTY->FULL: grant while empty. FULL->FULL: out_ready=1 and a grant (back-to-back).
//  - FULL->EMPTY: out_ready=1 and no in_valid. FULL & out_ready=0: hold out_data/out_sel stable; in_ready=0.
//  - ptr changes only on a grant; no grant leaves ptr unchanged.
//  - Wrap: grant of channel N_CH-1 sets ptr=0.
//  - All channels valid continuously: grant order ptr, ptr+1, ... cyclic; no channel starves (max wait N_CH-1 grants).
//  - in_valid with no grant: producer holds data; no drop, no duplicate.
//  - rst mid-stream: pending output beat discarded; ptr=0; no in_ready that cycle.
// CONFIGURATION
//  TDM_MUX_STATS_EN defined:
//   - adds output port beat_cnt (out, 16): count of output transfers.
//   - reset 0; +1 per output transfer; wraps 16'hFFFF -> 0.
//  Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  tdm_mux_pkg:
//   - constant N_CH_DEFAULT=8
//   - function sel_width(n) (clog2)
//   - typedef of the out state {EMPTY, FULL}
//  Sub-module rr_arbiter_n: combinational; inputs req[N_CH], ptr[SEL_W], en; outputs grant[N_CH] (onehot/zero), gnt_idx[SEL_W], gnt_any.
//  Top holds ptr, output register, optional counter.
// TESTING
//  1 Reset: rst=1 two cycles with all in_valid=1 -> in_ready=0, out_valid=0, out_sel=0, out_data=0.
//  2 Single beat: in_valid=8'b0010_0000, data ch5=1, out_ready=1 -> in_ready=8'b0010_0000 that cycle.
//    Next cycle: out_valid=1, out_sel=5, out_data=1; ptr=6.
//  3 Fairness + wrap: all in_valid=1, out_ready=1 from ptr=0 -> out_sel 0,1,..,7,0,1 on consecutive cycles.
//    out_valid stays 1 throughout.
//  4 Back-pressure: FULL with out_sel=3, out_ready=0 for 4 cycles -> out_sel/out_data stable, in_ready=0.
//    Then out_ready=1 -> next grant from ch4 if valid.
//  5 Reset mid-stream: pattern of test 3, rst=1 when out_sel=6 -> out_valid=0 next cycle.
//    After release, first grant is ch0.
//  6 TDM_MUX_STATS_EN: 10 output transfers -> beat_cnt=10; preload path to 16'hFFFF plus 1 transfer -> 0.
//  Scoreboard all tests: each accepted (ch,data) appears exactly once at output, in grant order.

Source files
------------

// File: rtl/tdm_mux_pkg.sv
// Shared constants, helpers and types for the round-robin TDM gather mux.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package tdm_mux_pkg;

    // Default fan-in of the gather mux.
    localparam int N_CH_DEFAULT = 8;

    // Width of a channel index for n channels; never narrower than one bit
    // so a 1-bit select still exists for the smallest legal fan-in.
    function automatic int sel_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // Occupancy of the single-entry output register.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/tdm_mux8_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: en=0 forces an all-zero grant so nothing is accepted.
module rr_arbiter_n
    import tdm_mux_pkg::*;
#(
    parameter int N_CH  = N_CH_DEFAULT,
    parameter int SEL_W = sel_width(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             en,
    output logic [N_CH-1:0]  grant,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_any
);

    // Candidate channel for the current search step. N_CH is a power of two,
    // so the SEL_W-bit add wraps modulo N_CH without an explicit compare.
    logic [SEL_W-1:0] cand_idx;

    // Walk ptr, ptr+1, ... and latch the first asserted request.
    always_comb begin
        grant    = '0;
        gnt_idx  = '0;
        gnt_any  = 1'b0;
        cand_idx = '0;
        if (en) begin
            for (int k = 0; k < N_CH; k++) begin
                cand_idx = ptr + SEL_W'(k);
                if (!gnt_any && req[cand_idx]) begin
                    gnt_any         = 1'b1;
                    gnt_idx         = cand_idx;
                    grant[cand_idx] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/tdm_mux8_rr.sv
// Round-robin TDM gather mux: N_CH valid/ready channels -> one tagged stream.
// Latency: 1 cycle from input accept to out_valid; 1 beat/cycle sustained.
// Backpressure: out_ready=0 with a full output register holds out_* and drops all in_ready.
// Optional: define TDM_MUX_STATS_EN to add the 16-bit beat_cnt output-transfer counter.
module tdm_mux8_rr
    import tdm_mux_pkg::*;
#(
    parameter int DATA_W = 1,
    parameter int N_CH   = N_CH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          in_valid,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    output logic [N_CH-1:0]          in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [sel_width(N_CH)-1:0] out_sel,
    input  logic                     out_ready
`ifdef TDM_MUX_STATS_EN
    ,
    output logic [15:0]              beat_cnt
`endif
);

    localparam int SEL_W = sel_width(N_CH);

    out_state_e        state_q, state_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_sel_q, out_sel_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;

    logic              load;
    logic              arb_en;
    logic [N_CH-1:0]   grant;
    logic [SEL_W-1:0]  gnt_idx;
    logic              gnt_any;
    logic [DATA_W-1:0] gnt_data;

    // The output register can take a new beat when it is empty or is being
    // drained this cycle. Reset suppresses every grant so no producer sees
    // a handshake that the reset would then swallow.
    assign load   = (state_q == EMPTY) || out_ready;
    assign arb_en = load && !rst;

    rr_arbiter_n #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_arb (
        .req     (in_valid),
        .ptr     (ptr_q),
        .en      (arb_en),
        .grant   (grant),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // The grant vector is the accept vector: at most one bit high.
    assign in_ready = grant;

    // AND-OR select of the granted channel's word (grant is one-hot or zero).
    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            gnt_data = gnt_data | ({DATA_W{grant[i]}} & in_data[i*DATA_W +: DATA_W]);
        end
    end

    // Output-register FSM plus ptr update: capture on grant, drain on out_ready.
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_sel_d  = out_sel_q;
        ptr_d      = ptr_q;

        // ptr only moves on a grant and always points one past the winner.
        if (gnt_any) begin
            ptr_d      = gnt_idx + SEL_W'(1);
            out_data_d = gnt_data;
            out_sel_d  = gnt_idx;
        end

        unique case (state_q)
            EMPTY: begin
                if (gnt_any) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                // Without out_ready there is no grant, so the held beat stays.
                if (out_ready) begin
                    state_d = gnt_any ? FULL : EMPTY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // State register; reset discards any pending beat and restarts at ch0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            out_data_q <= '0;
            out_sel_q  <= '0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_sel_q  <= out_sel_d;
            ptr_q      <= ptr_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

`ifdef TDM_MUX_STATS_EN
    logic [15:0] beat_cnt_q, beat_cnt_d;
    logic        out_xfer;

    assign out_xfer = out_valid && out_ready;

    // Count completed output transfers; natural 16-bit wrap at 16'hFFFF.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (out_xfer) begin
            beat_cnt_d = beat_cnt_q + 16'd1;
        end
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign beat_cnt = beat_cnt_q;
`endif

endmodule
